// File: rtl/serial_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_seq
//  Description : Bit-serial subtract sequencer. Accepts a WIDTH-bit
//                minuend/subtrahend pair plus borrow-in over a valid/ready
//                handshake. It walks the operands LSB-first through one
//                full-subtract cell, one bit per clock, with a registered
//                borrow. It then presents the difference and the final
//                borrow-out over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      synchronous active-low reset
//    in_valid   in   1      operand pair valid
//    in_ready   out  1      operands can be accepted (IDLE and out of reset)
//    a          in   WIDTH  minuend
//    b          in   WIDTH  subtrahend
//    bin        in   1      borrow-in for bit 0
//    out_valid  out  1      result valid
//    out_ready  in   1      consumer accepts result
//    diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//    bout       out  1      final borrow-out (a < b + bin)
//    busy       out  1      operation in flight or result pending
// ============================================================================
module serial_sub_seq #(
  parameter int WIDTH = 3,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] sd_next;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             bo;
  logic             last_bit;
  logic             accept;

  // The single subtract cell operating on the current LSBs.
  assign d        = sa[0] ^ sb[0] ^ br;
  assign bo       = (~sa[0] & (sb[0] | br)) | (sb[0] & br);
  assign last_bit = (cnt == LAST_CNT);

  // Difference bits enter at the MSB so that after WIDTH steps the LSB
  // computed first has arrived at bit 0. Written as shifts so that it also
  // covers WIDTH == 1 without a zero-width slice.
  assign sd_next  = (sd >> 1) | (WIDTH'(d) << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        // in_ready is gated by rst_n so nothing is offered while in reset.
        in_ready = rst_n;
        accept   = in_valid & rst_n;
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy = 1'b1;
        if (out_valid && out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand shifters, borrow, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa        <= '0;
      sb        <= '0;
      sd        <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sa  <= a;
            sb  <= b;
            sd  <= '0;
            br  <= bin;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_next;
          br  <= bo;
          cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff      <= sd_next;
            bout      <= bo;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // diff/bout are left untouched so they persist past the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_sub_seq
//  Description : Self-checking bench for serial_sub_seq. Three instances
//                (WIDTH 1, 3, 8) share clock, reset and operand buses; a
//                selector routes in_valid to one instance and muxes its
//                outputs back. Expected results come from plain integer
//                subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       bin;
  logic [7:0] a;
  logic [7:0] b;
  int         sel;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  logic       iv1, ir1, ov1, bo1, bz1;
  logic [0:0] d1;
  logic       iv3, ir3, ov3, bo3, bz3;
  logic [2:0] d3;
  logic       iv8, ir8, ov8, bo8, bz8;
  logic [7:0] d8;

  assign iv1 = in_valid && (sel == 1);
  assign iv3 = in_valid && (sel == 3);
  assign iv8 = in_valid && (sel == 8);

  serial_sub_seq #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a[0:0]), .b(b[0:0]), .bin(bin), .out_valid(ov1),
    .out_ready(out_ready), .diff(d1), .bout(bo1), .busy(bz1)
  );

  serial_sub_seq #(.WIDTH(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
    .a(a[2:0]), .b(b[2:0]), .bin(bin), .out_valid(ov3),
    .out_ready(out_ready), .diff(d3), .bout(bo3), .busy(bz3)
  );

  serial_sub_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a), .b(b), .bin(bin), .out_valid(ov8),
    .out_ready(out_ready), .diff(d8), .bout(bo8), .busy(bz8)
  );

  logic       m_ready, m_valid, m_bout, m_busy;
  logic [7:0] m_diff;

  always_comb begin
    m_ready = ir3;
    m_valid = ov3;
    m_bout  = bo3;
    m_busy  = bz3;
    m_diff  = {5'b0, d3};
    if (sel == 1) begin
      m_ready = ir1; m_valid = ov1; m_bout = bo1; m_busy = bz1; m_diff = {7'b0, d1};
    end else if (sel == 8) begin
      m_ready = ir8; m_valid = ov8; m_bout = bo8; m_busy = bz8; m_diff = d8;
    end
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer subtraction of the width-limited operands.
  task automatic model(input int w, input logic [7:0] av, input logic [7:0] bv,
                       input logic binv, output logic [7:0] ed, output logic eb);
    int mask;
    int r;
    mask = (1 << w) - 1;
    r    = (int'(av) & mask) - (int'(bv) & mask) - int'(binv);
    eb   = (r < 0);
    ed   = 8'(r & mask);
  endtask

  // Offer operands and hold in_valid until the accepting edge has passed.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic binv);
    int n;
    n = 0;
    a = av; b = bv; bin = binv; in_valid = 1'b1;
    while (!m_ready && n < 50) begin
      step();
      n++;
    end
    check_val("accept_ready", 16'(m_ready), 16'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid rises.
  task automatic wait_result(input int lat_exp);
    int n;
    n = 0;
    while (!m_valid && n < 60) begin
      step();
      n++;
    end
    check_val("latency", 16'(n), 16'(lat_exp));
  endtask

  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic binv, input bit rnd_ready);
    logic [7:0] ed;
    logic       eb;
    model(w, av, bv, binv, ed, eb);
    out_ready = !rnd_ready;
    send(av, bv, binv);
    wait_result(w);
    check_val("diff", 16'(m_diff), 16'(ed));
    check_val("bout", 16'(m_bout), 16'(eb));
    for (int k = 0; k < 20; k++) begin
      out_ready = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_ready) begin
        step();
        break;
      end
      step();
      check_val("hold_diff", 16'(m_diff), 16'(ed));
      check_val("hold_valid", 16'(m_valid), 16'd1);
    end
    check_val("post_valid", 16'(m_valid), 16'd0);
    check_val("post_ready", 16'(m_ready), 16'd1);
    check_val("post_busy", 16'(m_busy), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bin = 1'b0;
    a = '0; b = '0; sel = 3;

    // Reset state.
    step();
    step();
    check_val("rst_valid", 16'(m_valid), 16'd0);
    check_val("rst_diff",  16'(m_diff),  16'd0);
    check_val("rst_bout",  16'(m_bout),  16'd0);
    check_val("rst_busy",  16'(m_busy),  16'd0);
    check_val("rst_ready", 16'(m_ready), 16'd0);
    rst_n = 1'b1;
    #1;
    check_val("idle_ready", 16'(m_ready), 16'd1);

    // Directed operations.
    run_op(3, 8'd5, 8'd3, 1'b0, 1'b0);
    run_op(3, 8'd2, 8'd3, 1'b0, 1'b0);
    run_op(3, 8'd0, 8'd0, 1'b1, 1'b0);
    run_op(3, 8'd7, 8'd2, 1'b0, 1'b0);

    // Backpressure: result must hold for 5 cycles.
    out_ready = 1'b0;
    send(8'd4, 8'd1, 1'b0);
    wait_result(3);
    for (int k = 0; k < 5; k++) begin
      check_val("bp_valid", 16'(m_valid), 16'd1);
      check_val("bp_diff",  16'(m_diff),  16'd3);
      check_val("bp_bout",  16'(m_bout),  16'd0);
      check_val("bp_busy",  16'(m_busy),  16'd1);
      check_val("bp_ready", 16'(m_ready), 16'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check_val("bp_drop", 16'(m_valid), 16'd0);

    // in_valid held high with new operands during SHIFT/DONE is ignored.
    out_ready = 1'b0;
    a = 8'd6; b = 8'd2; bin = 1'b0; in_valid = 1'b1;
    step();
    a = 8'd7; b = 8'd7;
    wait_result(3);
    check_val("ign_diff", 16'(m_diff), 16'd4);
    check_val("ign_bout", 16'(m_bout), 16'd0);
    step();
    step();
    check_val("ign_hold", 16'(m_diff), 16'd4);
    check_val("ign_ready", 16'(m_ready), 16'd0);
    out_ready = 1'b1;
    step();
    check_val("ign_drop", 16'(m_valid), 16'd0);
    check_val("ign_idle", 16'(m_ready), 16'd1);
    step();
    in_valid = 1'b0;
    wait_result(3);
    check_val("ign2_diff", 16'(m_diff), 16'd0);
    check_val("ign2_bout", 16'(m_bout), 16'd0);
    step();
    check_val("ign2_drop", 16'(m_valid), 16'd0);

    // Reset during the second SHIFT cycle aborts the operation.
    out_ready = 1'b1;
    send(8'd5, 8'd3, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check_val("ar_ready_low", 16'(m_ready), 16'd0);
    step();
    check_val("ar_valid", 16'(m_valid), 16'd0);
    check_val("ar_diff",  16'(m_diff),  16'd0);
    check_val("ar_bout",  16'(m_bout),  16'd0);
    check_val("ar_busy",  16'(m_busy),  16'd0);
    rst_n = 1'b1;
    #1;
    check_val("ar_ready", 16'(m_ready), 16'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      check_val("ar_nopulse", 16'(m_valid), 16'd0);
    end
    run_op(3, 8'd3, 8'd4, 1'b0, 1'b0);

    // Exhaustive WIDTH=3 with random backpressure.
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      run_op(3, {5'b0, v[2:0]}, {5'b0, v[5:3]}, v[6], 1'b1);
    end

    // WIDTH=1 random regression.
    sel = 1;
    #1;
    for (int i = 0; i < 1000; i++) begin
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    // WIDTH=8 random regression.
    sel = 8;
    #1;
    for (int i = 0; i < 1000; i++) begin
      run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
